// File: rtl/apb_slave_mem_if.sv
// -----------------------------------------------------------------------------
// apb_slave_mem_if
// Bus bundle between an APB requester and one apb_slave_mem completer.
//   sel     requester -> completer  select for this completer
//   enable  requester -> completer  PENABLE
//   write   requester -> completer  1 = write, 0 = read
//   addr    requester -> completer  byte address
//   data    requester -> completer  write data
//   PRDATA  completer -> requester  read data
//   PREADY  completer -> requester  transfer complete
//   PSLVERR completer -> requester  error response, valid with PREADY
// -----------------------------------------------------------------------------
interface apb_slave_mem_if #(
    parameter int width = 32
);
    logic             sel;
    logic             enable;
    logic             write;
    logic [width-1:0] addr;
    logic [width-1:0] data;
    logic [width-1:0] PRDATA;
    logic             PREADY;
    logic             PSLVERR;

    modport master (
        output sel, enable, write, addr, data,
        input  PRDATA, PREADY, PSLVERR
    );

    modport slave (
        input  sel, enable, write, addr, data,
        output PRDATA, PREADY, PSLVERR
    );
endinterface

// File: rtl/apb_slave_mem.sv
// -----------------------------------------------------------------------------
// apb_slave_mem
// APB completer backed by a word-addressed memory of DEPTH words. Adds
// WAIT_CYCLES wait states to every access and answers misaligned or
// out-of-range addresses with PSLVERR (memory untouched, read data 0).
//
// Ports
//   PCLK    in   bus clock, all state changes on the rising edge
//   PRESET  in   synchronous active-high reset (clears FSM, outputs, memory)
//   bus     slave modport of apb_slave_mem_if (sel/enable/write/addr/data in,
//           PRDATA/PREADY/PSLVERR out, all outputs registered)
//
// Parameters
//   width        data/address width, must be 32
//   DEPTH        number of words, power of 2, 2..4096
//   WAIT_CYCLES  wait states per ACCESS phase, 0..15
//
// Build option
//   APB_SLV_RDONLY_REGION_EN  when defined, words with index >= DEPTH/2 are
//                             read-only; writes there get PSLVERR.
// -----------------------------------------------------------------------------
module apb_slave_mem #(
    parameter int width       = 32,
    parameter int DEPTH       = 256,
    parameter int WAIT_CYCLES = 0
) (
    input  logic             PCLK,
    input  logic             PRESET,
    apb_slave_mem_if.slave   bus
);

    localparam int          AW      = $clog2(DEPTH);
    localparam int unsigned DEPTH_U = DEPTH;

    typedef enum logic {
        S_IDLE,
        S_ACCESS
    } state_t;

    state_t           r_state;
    logic [3:0]       r_cnt;
    logic             r_write;
    logic             r_err;
    logic [AW-1:0]    r_idx;
    logic [width-1:0] r_wdata;
    logic             r_ready;
    logic             r_slverr;
    logic [width-1:0] r_rdata;
    logic [width-1:0] r_mem [DEPTH];

    state_t           w_state_nxt;
    logic [3:0]       w_cnt_nxt;
    logic             w_ready_nxt;
    logic             w_slverr_nxt;
    logic [width-1:0] w_rdata_nxt;
    logic             w_latch;
    logic             w_commit;
    logic             w_complete;
    logic             w_src_write;
    logic             w_src_err;
    logic [AW-1:0]    w_src_idx;

    logic             w_misalign;
    logic             w_range;
    logic             w_err_live;
    logic [AW-1:0]    w_idx_live;

    // Error classification of the address presented during the setup phase.
    assign w_misalign = |bus.addr[1:0];
    assign w_range    = bus.addr[width-1:2] >= (width-2)'(DEPTH);
    assign w_idx_live = bus.addr[AW+1:2];

`ifdef APB_SLV_RDONLY_REGION_EN
    // Upper half of the array is write-protected; top index bit marks it.
    assign w_err_live = w_misalign | w_range | (bus.write & w_idx_live[AW-1]);
`else
    assign w_err_live = w_misalign | w_range;
`endif

    always_comb begin
        w_state_nxt  = r_state;
        w_cnt_nxt    = r_cnt;
        w_ready_nxt  = 1'b0;
        w_slverr_nxt = 1'b0;
        w_rdata_nxt  = '0;
        w_latch      = 1'b0;
        w_commit     = 1'b0;
        w_complete   = 1'b0;
        w_src_write  = r_write;
        w_src_err    = r_err;
        w_src_idx    = r_idx;

        case (r_state)
            S_IDLE: begin
                if (bus.sel && !bus.enable) begin
                    w_state_nxt = S_ACCESS;
                    w_cnt_nxt   = 4'(WAIT_CYCLES);
                    w_latch     = 1'b1;
                    // PREADY is registered, so with no wait states the
                    // response must be built from the live setup values.
                    if (WAIT_CYCLES == 0) begin
                        w_complete  = 1'b1;
                        w_src_write = bus.write;
                        w_src_err   = w_err_live;
                        w_src_idx   = w_idx_live;
                    end
                end
            end
            S_ACCESS: begin
                if (r_ready) begin
                    w_commit    = r_write && !r_err;
                    w_state_nxt = S_IDLE;
                    w_cnt_nxt   = '0;
                end else if (bus.sel && bus.enable) begin
                    // Counting down to 1 here lands PREADY exactly
                    // WAIT_CYCLES access cycles after the first one.
                    if (r_cnt <= 4'd1) begin
                        w_cnt_nxt  = '0;
                        w_complete = 1'b1;
                    end else begin
                        w_cnt_nxt = r_cnt - 4'd1;
                    end
                end else begin
                    w_state_nxt = S_IDLE;
                    w_cnt_nxt   = '0;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_cnt_nxt   = '0;
            end
        endcase

        if (w_complete) begin
            w_ready_nxt  = 1'b1;
            w_slverr_nxt = w_src_err;
            if (!w_src_err && !w_src_write) begin
                w_rdata_nxt = r_mem[w_src_idx];
            end
        end
    end

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_ready  <= 1'b0;
            r_slverr <= 1'b0;
            r_rdata  <= '0;
            r_write  <= 1'b0;
            r_err    <= 1'b0;
            r_idx    <= '0;
            r_wdata  <= '0;
            for (int unsigned i = 0; i < DEPTH_U; i++) begin
                r_mem[AW'(i)] <= '0;
            end
        end else begin
            r_state  <= w_state_nxt;
            r_cnt    <= w_cnt_nxt;
            r_ready  <= w_ready_nxt;
            r_slverr <= w_slverr_nxt;
            r_rdata  <= w_rdata_nxt;
            if (w_latch) begin
                r_write <= bus.write;
                r_err   <= w_err_live;
                r_idx   <= w_idx_live;
                r_wdata <= bus.data;
            end
            if (w_commit) begin
                r_mem[r_idx] <= r_wdata;
            end
        end
    end

    assign bus.PREADY  = r_ready;
    assign bus.PSLVERR = r_slverr;
    assign bus.PRDATA  = r_rdata;

endmodule

// File: tb/tb_apb_slave_mem.sv
// -----------------------------------------------------------------------------
// tb_apb_slave_mem
// Three completers (0, 2 and 3 wait states) share one requester; each has its
// own select line. Directed vectors with hand-computed results, followed by
// sequences for abort, back-to-back, protocol error and reset mid-transfer.
// -----------------------------------------------------------------------------
module tb_apb_slave_mem;

`ifdef APB_SLV_RDONLY_REGION_EN
    localparam bit RO = 1'b1;
`else
    localparam bit RO = 1'b0;
`endif

    logic        PCLK;
    logic        PRESET;
    logic [2:0]  sel_v;
    logic        enable_v;
    logic        write_v;
    logic [31:0] addr_v;
    logic [31:0] data_v;

    logic        rdy   [3];
    logic        slerr [3];
    logic [31:0] prd   [3];

    int n_pass;
    int n_total;

    apb_slave_mem_if #(.width(32)) if0 ();
    apb_slave_mem_if #(.width(32)) if2 ();
    apb_slave_mem_if #(.width(32)) if3 ();

    assign if0.sel = sel_v[0];
    assign if2.sel = sel_v[1];
    assign if3.sel = sel_v[2];
    assign if0.enable = enable_v;
    assign if2.enable = enable_v;
    assign if3.enable = enable_v;
    assign if0.write = write_v;
    assign if2.write = write_v;
    assign if3.write = write_v;
    assign if0.addr = addr_v;
    assign if2.addr = addr_v;
    assign if3.addr = addr_v;
    assign if0.data = data_v;
    assign if2.data = data_v;
    assign if3.data = data_v;

    assign rdy[0] = if0.PREADY;
    assign rdy[1] = if2.PREADY;
    assign rdy[2] = if3.PREADY;
    assign slerr[0] = if0.PSLVERR;
    assign slerr[1] = if2.PSLVERR;
    assign slerr[2] = if3.PSLVERR;
    assign prd[0] = if0.PRDATA;
    assign prd[1] = if2.PRDATA;
    assign prd[2] = if3.PRDATA;

    apb_slave_mem #(.width(32), .DEPTH(256), .WAIT_CYCLES(0)) u_dut0 (
        .PCLK(PCLK), .PRESET(PRESET), .bus(if0)
    );
    apb_slave_mem #(.width(32), .DEPTH(256), .WAIT_CYCLES(2)) u_dut2 (
        .PCLK(PCLK), .PRESET(PRESET), .bus(if2)
    );
    apb_slave_mem #(.width(32), .DEPTH(256), .WAIT_CYCLES(3)) u_dut3 (
        .PCLK(PCLK), .PRESET(PRESET), .bus(if3)
    );

    initial PCLK = 1'b0;
    always #5 PCLK = ~PCLK;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Setup + access; returns at the negedge of the PREADY cycle with the bus
    // still driven, so a following call starts its setup in the next cycle.
    task automatic xfer(input int d, input logic wr, input logic [31:0] a,
                        input logic [31:0] wd, output logic [31:0] rd,
                        output logic er, output int lat);
        bit done;
        done = 1'b0;
        @(posedge PCLK); #1;
        sel_v = '0; sel_v[d] = 1'b1;
        enable_v = 1'b0; write_v = wr; addr_v = a; data_v = wd;
        @(posedge PCLK); #1;
        enable_v = 1'b1;
        // Scramble the bus: the completer must use the setup-phase values.
        addr_v = 32'hFFFF_FFF3; data_v = ~wd; write_v = ~wr;
        lat = 1; rd = '0; er = 1'b0;
        for (int k = 0; k < 40 && !done; k++) begin
            @(negedge PCLK);
            if (rdy[d]) begin
                rd = prd[d]; er = slerr[d]; done = 1'b1;
            end else begin
                chk("slverr_while_wait", 32'(slerr[d]), 32'd0);
                lat++;
                @(posedge PCLK); #1;
            end
        end
        if (!done) chk("pready_timeout", 32'd0, 32'd1);
    endtask

    task automatic idle(input int d);
        @(posedge PCLK); #1;
        sel_v = '0; enable_v = 1'b0;
        @(negedge PCLK);
        chk("idle_pready", 32'(rdy[d]), 32'd0);
        chk("idle_prdata", prd[d], 32'd0);
    endtask

    typedef struct {
        int          d;
        logic        wr;
        logic [31:0] a;
        logic [31:0] wd;
        logic [31:0] exp_rd;
        logic        exp_er;
        int          exp_lat;
    } vec_t;

    localparam int NV = 18;
    vec_t vt [NV];

    initial begin : main
        logic [31:0] rd, rd2;
        logic        er, er2;
        int          lat, lat2;

        n_pass = 0; n_total = 0;
        sel_v = '0; enable_v = 1'b0; write_v = 1'b0; addr_v = '0; data_v = '0;

        vt[0]  = '{0, 1'b1, 32'h010, 32'hDEADBEEF, 32'h0,        1'b0, 1};
        vt[1]  = '{0, 1'b0, 32'h010, 32'h0,        32'hDEADBEEF, 1'b0, 1};
        vt[2]  = '{0, 1'b1, 32'h400, 32'h11111111, 32'h0,        1'b1, 1};
        vt[3]  = '{0, 1'b1, 32'h006, 32'h22222222, 32'h0,        1'b1, 1};
        vt[4]  = '{0, 1'b0, 32'h004, 32'h0,        32'h0,        1'b0, 1};
        vt[5]  = '{0, 1'b0, 32'h000, 32'h0,        32'h0,        1'b0, 1};
        vt[6]  = '{0, 1'b0, 32'h400, 32'h0,        32'h0,        1'b1, 1};
        vt[7]  = '{0, 1'b0, 32'h3FC, 32'h0,        32'h0,        1'b0, 1};
        vt[8]  = '{0, 1'b1, 32'h3FC, 32'hCAFEF00D, 32'h0,        1'b0, 1};
        vt[9]  = '{0, 1'b0, 32'h3FC, 32'h0,        32'hCAFEF00D, 1'b0, 1};
        vt[10] = '{0, 1'b1, 32'h200, 32'h5A5A0001, 32'h0,        RO,   1};
        vt[11] = '{0, 1'b0, 32'h200, 32'h0,        RO ? 32'h0 : 32'h5A5A0001, 1'b0, 1};
        vt[12] = '{0, 1'b1, 32'h1FC, 32'h00000077, 32'h0,        1'b0, 1};
        vt[13] = '{0, 1'b0, 32'h1FC, 32'h0,        32'h00000077, 1'b0, 1};
        vt[14] = '{2, 1'b0, 32'h000, 32'h0,        32'h0,        1'b0, 4};
        vt[15] = '{2, 1'b1, 32'h008, 32'h00000033, 32'h0,        1'b0, 4};
        vt[16] = '{2, 1'b0, 32'h008, 32'h0,        32'h00000033, 1'b0, 4};
        vt[17] = '{2, 1'b0, 32'h006, 32'h0,        32'h0,        1'b1, 4};

        PRESET = 1'b1;
        repeat (3) @(posedge PCLK);
        #1 PRESET = 1'b0;
        @(negedge PCLK);
        for (int i = 0; i < 3; i++) begin
            chk("reset_pready", 32'(rdy[i]), 32'd0);
            chk("reset_pslverr", 32'(slerr[i]), 32'd0);
            chk("reset_prdata", prd[i], 32'd0);
        end

        for (int i = 0; i < NV; i++) begin
            xfer(vt[i].d, vt[i].wr, vt[i].a, vt[i].wd, rd, er, lat);
            chk($sformatf("v%0d_prdata", i), rd, vt[i].exp_rd);
            chk($sformatf("v%0d_pslverr", i), 32'(er), 32'(vt[i].exp_er));
            chk($sformatf("v%0d_latency", i), 32'(lat), 32'(vt[i].exp_lat));
            idle(vt[i].d);
        end

        // Abort on the 2-wait-state completer: enable dropped in access cycle 2.
        @(posedge PCLK); #1;
        sel_v = 3'b010; enable_v = 1'b0; write_v = 1'b1; addr_v = 32'h20; data_v = 32'h1234;
        @(posedge PCLK); #1;
        enable_v = 1'b1;
        @(negedge PCLK);
        chk("abort_acc1_pready", 32'(rdy[1]), 32'd0);
        @(posedge PCLK); #1;
        enable_v = 1'b0;
        @(negedge PCLK);
        chk("abort_acc2_pready", 32'(rdy[1]), 32'd0);
        @(posedge PCLK); #1;
        sel_v = '0;
        for (int k = 0; k < 3; k++) begin
            @(negedge PCLK);
            chk("abort_after_pready", 32'(rdy[1]), 32'd0);
        end
        xfer(1, 1'b0, 32'h20, 32'h0, rd, er, lat);
        chk("abort_readback", rd, 32'h0);
        chk("abort_read_latency", 32'(lat), 32'd3);
        idle(1);

        // Back-to-back write then read with no idle cycle in between.
        xfer(0, 1'b1, 32'h4, 32'hA5A5A5A5, rd, er, lat);
        xfer(0, 1'b0, 32'h4, 32'h0, rd2, er2, lat2);
        chk("b2b_wr_pslverr", 32'(er), 32'd0);
        chk("b2b_rd_prdata", rd2, 32'hA5A5A5A5);
        chk("b2b_rd_pslverr", 32'(er2), 32'd0);
        chk("b2b_second_pready_cycle", 32'(lat + 1 + lat2), 32'd3);
        idle(0);

        // sel & enable without a setup phase must be ignored.
        @(posedge PCLK); #1;
        sel_v = 3'b001; enable_v = 1'b1; write_v = 1'b1; addr_v = 32'h10; data_v = 32'h0BAD0BAD;
        for (int k = 0; k < 3; k++) begin
            @(negedge PCLK);
            chk("proto_err_pready", 32'(rdy[0]), 32'd0);
        end
        @(posedge PCLK); #1;
        sel_v = '0; enable_v = 1'b0;
        xfer(0, 1'b0, 32'h10, 32'h0, rd, er, lat);
        chk("proto_err_mem", rd, 32'hDEADBEEF);
        idle(0);

        // Reset in the middle of a wait-stated write.
        @(posedge PCLK); #1;
        sel_v = 3'b100; enable_v = 1'b0; write_v = 1'b1; addr_v = 32'hC; data_v = 32'h99;
        @(posedge PCLK); #1;
        enable_v = 1'b1;
        @(posedge PCLK); #1;
        PRESET = 1'b1; sel_v = '0; enable_v = 1'b0;
        @(posedge PCLK); #1;
        PRESET = 1'b0;
        @(negedge PCLK);
        chk("rst_mid_pready", 32'(rdy[2]), 32'd0);
        chk("rst_mid_prdata", prd[2], 32'd0);
        xfer(2, 1'b0, 32'hC, 32'h0, rd, er, lat);
        chk("rst_mid_no_write", rd, 32'h0);
        idle(2);
        xfer(2, 1'b0, 32'h8, 32'h0, rd, er, lat);
        chk("rst_clears_mem3", rd, 32'h0);
        idle(2);
        xfer(0, 1'b0, 32'h10, 32'h0, rd, er, lat);
        chk("rst_clears_mem0", rd, 32'h0);
        idle(0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
